// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter
//   Round-robin arbiter and sequencer in front of the shared combinational ALU.
//   Two requesters hand over one operation each through a valid/ready
//   handshake. The winner's operation is registered and held on the alu_*
//   outputs, and the ALU result is captured one cycle later. The captured
//   result is then presented on a single response channel tagged with the
//   requester id.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid / reqN_ready     request handshake, N = 0, 1
//   reqN_x, reqN_y              operands
//   reqN_mod                    {nx, ix, sx, ny, iy, sy}
//   reqN_op                     4-bit ALU opcode (14 and 15 are illegal)
//   alu_x, alu_y, alu_n*/i*/s*  registered operands and modifiers to the ALU
//   alu_op                      registered opcode to the ALU
//   alu_out                     combinational ALU result
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_data            requester index and result
//   rsp_zero, rsp_err           result-is-zero and illegal-opcode flags
//   busy                        high whenever an operation is in flight
//
// state | meaning
// IDLE  | waiting for a request; grants one combinationally and latches it
// EXEC  | ALU driven from operand registers; result captured at the clock edge
// RESP  | response held on rsp_* until rsp_ready
module alu_op_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  input  logic [5:0]        req0_mod,
  input  logic [3:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  input  logic [5:0]        req1_mod,
  input  logic [3:0]        req1_op,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic              alu_nx,
  output logic              alu_ix,
  output logic              alu_sx,
  output logic              alu_ny,
  output logic              alu_iy,
  output logic              alu_sy,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              illegal;
  logic [DATA_W-1:0] opnd_x;
  logic [DATA_W-1:0] opnd_y;
  logic [5:0]        opnd_mod;
  logic [3:0]        opnd_op;
  logic              opnd_id;
  logic [DATA_W-1:0] res_data;
  logic              res_zero;
  logic              res_err;

  // last_grant = 1 means requester 0 has priority on the next tie.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || last_grant)) begin
          grant0 = 1'b1;
        end else if (req1_valid) begin
          grant1 = 1'b1;
        end
        if (req0_valid || req1_valid) begin
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept  = grant0 | grant1;
  assign illegal = &opnd_op[3:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      opnd_x     <= '0;
      opnd_y     <= '0;
      opnd_mod   <= '0;
      opnd_op    <= '0;
      opnd_id    <= 1'b0;
      res_data   <= '0;
      res_zero   <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= grant1;
        opnd_id    <= grant1;
        opnd_x     <= grant1 ? req1_x   : req0_x;
        opnd_y     <= grant1 ? req1_y   : req0_y;
        opnd_mod   <= grant1 ? req1_mod : req0_mod;
        opnd_op    <= grant1 ? req1_op  : req0_op;
      end
      if (state == EXEC) begin
        // Illegal opcodes ignore the ALU and report a forced zero result.
        res_data <= illegal ? '0 : alu_out;
        res_zero <= illegal ? 1'b1 : (alu_out == '0);
        res_err  <= illegal;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign alu_x  = opnd_x;
  assign alu_y  = opnd_y;
  assign alu_nx = opnd_mod[5];
  assign alu_ix = opnd_mod[4];
  assign alu_sx = opnd_mod[3];
  assign alu_ny = opnd_mod[2];
  assign alu_iy = opnd_mod[1];
  assign alu_sy = opnd_mod[0];
  assign alu_op = opnd_op;

  assign rsp_valid = (state == RESP);
  assign rsp_id    = opnd_id;
  assign rsp_data  = res_data;
  assign rsp_zero  = res_zero;
  assign rsp_err   = res_err;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_op_arbiter.sv
module tb_alu_op_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_x, req0_y, req1_x, req1_y;
  logic [5:0]  req0_mod, req1_mod;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_x, alu_y, alu_out;
  logic        alu_nx, alu_ix, alu_sx, alu_ny, alu_iy, alu_sy;
  logic [3:0]  alu_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  alu_op_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_mod(req0_mod), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y), .req1_mod(req1_mod), .req1_op(req1_op),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_nx(alu_nx), .alu_ix(alu_ix), .alu_sx(alu_sx),
    .alu_ny(alu_ny), .alu_iy(alu_iy), .alu_sy(alu_sy),
    .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: n* inverts, i* increments; shift modifiers are not used here.
  logic [31:0] mx, my;
  always_comb begin
    mx = alu_nx ? ~alu_x : alu_x;
    if (alu_ix) mx = mx + 32'd1;
    my = alu_ny ? ~alu_y : alu_y;
    if (alu_iy) my = my + 32'd1;
    case (alu_op)
      4'd0:    alu_out = mx + my;
      4'd1:    alu_out = mx - my;
      4'd2:    alu_out = mx & my;
      4'd3:    alu_out = mx | my;
      4'd4:    alu_out = mx ^ my;
      default: alu_out = 32'h1234_5678;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req0(input logic v, input logic [31:0] x, input logic [31:0] y,
                          input logic [5:0] m, input logic [3:0] o);
    req0_valid = v; req0_x = x; req0_y = y; req0_mod = m; req0_op = o;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] x, input logic [31:0] y,
                          input logic [5:0] m, input logic [3:0] o);
    req1_valid = v; req1_x = x; req1_y = y; req1_mod = m; req1_op = o;
  endtask

  // Waits (bounded) for rsp_valid at a negedge, checks the response, then
  // steps past the following posedge where the handshake happens if rsp_ready.
  task automatic wait_rsp(input string tag, input logic id, input logic [31:0] data,
                          input logic zero, input logic err, output int seen_cyc);
    logic found = 1'b0;
    seen_cyc = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1'b1;
        seen_cyc = cyc;
      end
    end
    check_val({tag, "_seen"}, {31'b0, found}, 32'd1);
    check_val({tag, "_id"},   {31'b0, rsp_id}, {31'b0, id});
    check_val({tag, "_data"}, rsp_data, data);
    check_val({tag, "_zero"}, {31'b0, rsp_zero}, {31'b0, zero});
    check_val({tag, "_err"},  {31'b0, rsp_err}, {31'b0, err});
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, {30'b0, req1_ready, req0_ready}, 32'd0);
    check_val({tag, "_rspv_busy"}, {30'b0, rsp_valid, busy}, 32'd0);
    check_val({tag, "_alu_x"}, alu_x, 32'd0);
    check_val({tag, "_alu_y"}, alu_y, 32'd0);
    check_val({tag, "_alu_ctl"},
              {22'b0, alu_op, alu_nx, alu_ix, alu_sx, alu_ny, alu_iy, alu_sy}, 32'd0);
    check_val({tag, "_rsp"}, {29'b0, rsp_id, rsp_zero, rsp_err}, 32'd0);
    check_val({tag, "_rsp_data"}, rsp_data, 32'd0);
  endtask

  int t0, c_prev, c_now;
  logic exp_id;
  logic [31:0] exp_data;

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_req0(1'b0, 32'd0, 32'd0, 6'd0, 4'd0);
    set_req1(1'b0, 32'd0, 32'd0, 6'd0, 4'd0);
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with both requesters valid; first tie goes to requester 0.
    @(negedge clk);
    set_req0(1'b1, 32'd1, 32'd1, 6'd0, 4'd0);
    set_req1(1'b1, 32'd10, 32'd20, 6'd0, 4'd0);
    #1;
    check_val("rr_first_tie", {30'b0, req1_ready, req0_ready}, 32'd1);
    c_prev = -1;
    for (int i = 0; i < 4; i++) begin
      exp_id   = i[0];
      exp_data = i[0] ? 32'd30 : 32'd2;
      wait_rsp("rr", exp_id, exp_data, 1'b0, 1'b0, c_now);
      if (i > 0) check_val("rr_spacing", c_now - c_prev, 32'd3);
      c_prev = c_now;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Single request with latency check.
    @(negedge clk);
    set_req0(1'b1, 32'd5, 32'd3, 6'd0, 4'd0);
    #1;
    check_val("single_ready", {30'b0, req1_ready, req0_ready}, 32'd1);
    t0 = cyc;
    @(negedge clk);
    req0_valid = 1'b0;
    check_val("single_exec_busy", {30'b0, busy, rsp_valid}, 32'd2);
    check_val("single_exec_alu", {alu_x[15:0], alu_y[15:0]}, {16'd5, 16'd3});
    wait_rsp("single", 1'b0, 32'd8, 1'b0, 1'b0, c_now);
    check_val("single_latency", c_now - t0, 32'd2);

    // Back-pressure with a pending request from requester 1.
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req0(1'b1, 32'd100, 32'd1, 6'd0, 4'd0);
    #1;
    check_val("bp_accept", {30'b0, req1_ready, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    set_req1(1'b1, 32'd2, 32'd3, 6'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("bp_hold_rsp", {28'b0, rsp_valid, rsp_id, req1_ready, req0_ready}, 32'h8);
      check_val("bp_hold_data", rsp_data, 32'd101);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("bp_next_accept", {29'b0, busy, req1_ready, req0_ready}, 32'd2);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp("bp_pending", 1'b1, 32'd5, 1'b0, 1'b0, c_now);

    // Illegal opcode from requester 1.
    @(negedge clk);
    set_req1(1'b1, 32'hFFFF_FFFF, 32'd0, 6'd0, 4'd15);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp("illegal", 1'b1, 32'd0, 1'b1, 1'b1, c_now);

    // Zero result through y modifiers: 7 + (~7 + 1) = 0.
    @(negedge clk);
    set_req0(1'b1, 32'd7, 32'd7, 6'b000110, 4'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    check_val("zero_exec_mods", {26'b0, alu_nx, alu_ix, alu_sx, alu_ny, alu_iy, alu_sy},
              32'b000110);
    wait_rsp("zero", 1'b0, 32'd0, 1'b1, 1'b0, c_now);

    // Reset in the middle of RESP, then first tie goes to requester 0 again.
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req1(1'b1, 32'd1, 32'd2, 6'b100000, 4'd3);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check_val("mid_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req0(1'b1, 32'd4, 32'd4, 6'd0, 4'd0);
    set_req1(1'b1, 32'd9, 32'd9, 6'd0, 4'd0);
    #1;
    check_val("post_rst_tie", {30'b0, req1_ready, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp("post_rst", 1'b0, 32'd8, 1'b0, 1'b0, c_now);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_arbiter.md
# alu_op_arbiter

Two-port arbiter and sequencer for the shared 32-bit RISC-V ALU. Two requesters each present one operation (operands, x/y modifier bits, 4-bit opcode) with a valid/ready handshake. The block grants them round-robin, drives the combinational ALU from registered operands for one cycle, and captures the result. It returns the result on a single response channel tagged with the requester id. It sits between the issue logic and the ALU, so the ALU has exactly one driver.

## Interface
- DATA_W, 32, operand/result width; must match the ALU.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_x, req0_y / req1_x, req1_y  in  DATA_W  operands
- req0_mod / req1_mod  in  6  {nx, ix, sx, ny, iy, sy}
- req0_op / req1_op  in  4  ALU opcode
- alu_x, alu_y  out  DATA_W  ALU operands
- alu_nx, alu_ix, alu_sx, alu_ny, alu_iy, alu_sy  out  1  ALU modifier bits
- alu_op  out  4  ALU opcode
- alu_out  in  DATA_W  combinational ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index of the response
- rsp_data  out  DATA_W  result
- rsp_zero  out  1  rsp_data == 0
- rsp_err  out  1  opcode was illegal (14 or 15)
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid, the arbiter selects a winner and asserts reqN_ready for the winner only, combinationally, in that cycle.
  - It latches x, y, mod, op and the id into operand registers and moves to EXEC.
  - With no valid request it stays in IDLE.
- Arbitration: round-robin on a last_grant register.
  - Only one request valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - last_grant updates on each accept.
- EXEC:
  - alu_* are driven from the operand registers.
  - At the clock edge, alu_out is captured into the result register and zero/err are computed. The FSM moves to RESP.
  - Illegal opcode (14, 15): the ALU is not consulted. rsp_data = 0, rsp_zero = 1, rsp_err = 1.
- RESP:
  - rsp_valid = 1 and rsp_* are held stable until rsp_valid && rsp_ready.
  - On that handshake the FSM goes to IDLE.
  - No request is accepted in RESP or EXEC (both req_ready = 0).
- alu_* outputs:
  - Driven from the operand registers in every state; they are zeroed at reset.
  - They change only on accept.
- rsp_zero is computed from the captured DATA_W result, not from any ALU flag.

## Timing
- Reset (async on rst_n low):
  - State: IDLE, last_grant = 1, so requester 0 wins the first tie.
  - All outputs 0: req*_ready, alu_*, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, busy.
- Latency:
  - Accept in cycle T (IDLE).
  - EXEC in T+1.
  - rsp_valid high from T+2.
- Minimum issue interval: 3 cycles (accept, EXEC, RESP with rsp_ready = 1).
  - A new accept is possible the cycle after the response handshake.
- Back-pressure: rsp_ready low holds RESP indefinitely, with outputs stable. Requesters see req_ready = 0 throughout.
- A requester deasserting valid before being granted is legal. A requester that is granted must not be re-granted while busy.
- Reset mid-operation (EXEC or RESP): the transaction is dropped with no response, and all outputs return to reset values immediately.
- Simultaneous accept and rsp handshake cannot occur (different states).

## Test plan
- Reset values: assert rst_n = 0 mid-RESP -> rsp_valid, busy, req*_ready, and all alu_* go to 0 asynchronously; after release, first tie goes to requester 0.
- Single request: req0 op=0 (add), x=5, y=3, mod=0 -> req0_ready in cycle T; rsp_valid at T+2 with rsp_id=0, rsp_data=8, rsp_zero=0, rsp_err=0.
- Round-robin: both valid continuously, rsp_ready = 1.
  - req0: op=0, x=1, y=1.
  - req1: op=0, x=10, y=20.
  - Expected responses alternate ids 0, 1, 0, 1 with data 2, 30, 2, 30, spaced 3 cycles apart.
- Back-pressure: hold rsp_ready = 0 for 10 cycles during RESP -> rsp_* stable, no req_ready pulses; on rsp_ready = 1 the response completes and a pending request is accepted the next cycle.
- Illegal opcode: req1 op=15, x=0xFFFFFFFF -> rsp_id=1, rsp_data=0, rsp_zero=1, rsp_err=1.
- Zero result and modifiers: req0 op=0, x=7, y=7, mod = {0,0,0,1,1,0} (negate and increment y) -> rsp_data=0, rsp_zero=1; alu_ny = alu_iy = 1 observed during EXEC.
